// File: rtl/rvfi_monitor.sv
// rvfi_monitor -- run-time checker for a single-retire RVFI trace.
//
// Watches the RISC-V Formal Interface retirement stream and flags protocol
// or architectural violations:
//   code 1 PC     : pc_rdata does not follow the previous pc_wdata (skipped on interrupts
//                   and on the first retirement after reset/clear)
//   code 2 X0     : write of a non-zero value to x0
//   code 3 RS1    : rs1 read value disagrees with the shadow register file
//   code 4 RS2    : rs2 read value disagrees with the shadow register file
//   code 5 ALIGN  : non-trapping retirement with odd next PC
// The lowest code wins when several fire together. The first violation halts
// the monitor (FAIL) until clear or reset.
//
// Optional feature: define RVFI_MONITOR_REGFILE_EN to build the 31-entry shadow
// register file and enable codes 3/4. Without it no shadow storage exists.
//
// Ports:
//   g_clk, g_resetn    clock, asynchronous active-low reset
//   clear              synchronous restart (drops any same-cycle retirement)
//   rvfi_*             retirement trace inputs
//   err_valid/err_code one-cycle violation pulse and its code
//   err_sticky         latched failure flag
//   retire_count       retirements accepted since reset/clear (frozen in FAIL)

module rvfi_monitor #(
    parameter int XLEN = 64,
    parameter int ILEN = 32,
    parameter int NRET = 1
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            clear,
    input  logic            rvfi_valid,
    input  logic [ILEN-1:0] rvfi_insn,
    input  logic            rvfi_trap,
    input  logic            rvfi_intr,
    input  logic [4:0]      rvfi_rs1_addr,
    input  logic [4:0]      rvfi_rs2_addr,
    input  logic [4:0]      rvfi_rd_addr,
    input  logic [XLEN-1:0] rvfi_rs1_rdata,
    input  logic [XLEN-1:0] rvfi_rs2_rdata,
    input  logic [XLEN-1:0] rvfi_rd_wdata,
    input  logic [XLEN-1:0] rvfi_pc_rdata,
    input  logic [XLEN-1:0] rvfi_pc_wdata,
    output logic            err_valid,
    output logic [2:0]      err_code,
    output logic            err_sticky,
    output logic [63:0]     retire_count
);

    generate
        if (NRET != 1) begin : g_nret_check
            $error("rvfi_monitor supports NRET == 1 only");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, FAIL} state_t;

    state_t          state;
    logic [XLEN-1:0] exp_pc;
    logic            active;
    logic            rs1_bad;
    logic            rs2_bad;
    logic [2:0]      code;

    // The instruction word itself is never checked.
    logic unused_insn;
    assign unused_insn = ^rvfi_insn;

    // A retirement is only considered when the monitor is live and not being
    // restarted this cycle.
    assign active = rvfi_valid && !clear && (state != FAIL);

`ifdef RVFI_MONITOR_REGFILE_EN
    logic [31:1]     sh_vld;
    logic [XLEN-1:0] sh_data [1:31];
    logic            sh_we;

    assign sh_we = active && !rvfi_trap && (rvfi_rd_addr != 5'd0);

    // Reads see the pre-write contents since the write lands at the edge.
    assign rs1_bad = (rvfi_rs1_addr != 5'd0) && sh_vld[rvfi_rs1_addr]
                     && (rvfi_rs1_rdata != sh_data[rvfi_rs1_addr]);
    assign rs2_bad = (rvfi_rs2_addr != 5'd0) && sh_vld[rvfi_rs2_addr]
                     && (rvfi_rs2_rdata != sh_data[rvfi_rs2_addr]);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn)
            sh_vld <= '0;
        else if (clear)
            sh_vld <= '0;
        else if (sh_we)
            sh_vld[rvfi_rd_addr] <= 1'b1;
    end

    // Shadow data needs no reset: its valid bit gates every use.
    always_ff @(posedge g_clk) begin
        if (sh_we)
            sh_data[rvfi_rd_addr] <= rvfi_rd_wdata;
    end
`else
    logic unused_rs;
    assign unused_rs = ^{rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata};
    assign rs1_bad   = 1'b0;
    assign rs2_bad   = 1'b0;
`endif

    // Priority encode: lowest code wins.
    always_comb begin
        code = 3'd0;
        if (state == RUN && !rvfi_intr && rvfi_pc_rdata != exp_pc)
            code = 3'd1;
        else if (rvfi_rd_addr == 5'd0 && rvfi_rd_wdata != '0)
            code = 3'd2;
        else if (rs1_bad)
            code = 3'd3;
        else if (rs2_bad)
            code = 3'd4;
        else if (!rvfi_trap && rvfi_pc_wdata[0])
            code = 3'd5;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state        <= IDLE;
            exp_pc       <= '0;
            retire_count <= '0;
            err_valid    <= 1'b0;
            err_code     <= 3'd0;
            err_sticky   <= 1'b0;
        end else if (clear) begin
            state        <= IDLE;
            exp_pc       <= '0;
            retire_count <= '0;
            err_valid    <= 1'b0;
            err_code     <= 3'd0;
            err_sticky   <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            err_code  <= 3'd0;
            if (active) begin
                retire_count <= retire_count + 64'd1;
                exp_pc       <= rvfi_pc_wdata;
                if (code != 3'd0) begin
                    err_valid  <= 1'b1;
                    err_code   <= code;
                    err_sticky <= 1'b1;
                    state      <= FAIL;
                end else begin
                    state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_rvfi_monitor.sv
// Directed self-checking bench for rvfi_monitor.
module tb_rvfi_monitor;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    logic            g_clk = 1'b0;
    logic            g_resetn = 1'b0;
    logic            clear = 1'b0;
    logic            rvfi_valid = 1'b0;
    logic [ILEN-1:0] rvfi_insn = '0;
    logic            rvfi_trap = 1'b0;
    logic            rvfi_intr = 1'b0;
    logic [4:0]      rvfi_rs1_addr = '0;
    logic [4:0]      rvfi_rs2_addr = '0;
    logic [4:0]      rvfi_rd_addr = '0;
    logic [XLEN-1:0] rvfi_rs1_rdata = '0;
    logic [XLEN-1:0] rvfi_rs2_rdata = '0;
    logic [XLEN-1:0] rvfi_rd_wdata = '0;
    logic [XLEN-1:0] rvfi_pc_rdata = '0;
    logic [XLEN-1:0] rvfi_pc_wdata = '0;
    logic            err_valid;
    logic [2:0]      err_code;
    logic            err_sticky;
    logic [63:0]     retire_count;

    int checks = 0;
    int errors = 0;

    rvfi_monitor #(.XLEN(XLEN), .ILEN(ILEN), .NRET(1)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .clear(clear),
        .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .err_valid(err_valid), .err_code(err_code),
        .err_sticky(err_sticky), .retire_count(retire_count)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; returns at the following falling edge where outputs are stable.
    task automatic step();
        @(posedge g_clk);
        @(negedge g_clk);
    endtask

    task automatic retire(input logic [63:0] pc_r, input logic [63:0] pc_w,
                          input logic [4:0] rd, input logic [63:0] wd,
                          input logic [4:0] rs1, input logic [63:0] rs1d,
                          input logic [4:0] rs2, input logic [63:0] rs2d,
                          input logic intr, input logic trap);
        rvfi_valid     = 1'b1;
        rvfi_insn      = $urandom;
        rvfi_pc_rdata  = pc_r;
        rvfi_pc_wdata  = pc_w;
        rvfi_rd_addr   = rd;
        rvfi_rd_wdata  = wd;
        rvfi_rs1_addr  = rs1;
        rvfi_rs1_rdata = rs1d;
        rvfi_rs2_addr  = rs2;
        rvfi_rs2_rdata = rs2d;
        rvfi_intr      = intr;
        rvfi_trap      = trap;
        step();
        rvfi_valid = 1'b0;
        rvfi_intr  = 1'b0;
        rvfi_trap  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge g_clk);
        step();
        chk("rst_err_valid", {63'd0, err_valid}, 64'd0);
        chk("rst_err_code", {61'd0, err_code}, 64'd0);
        chk("rst_sticky", {63'd0, err_sticky}, 64'd0);
        chk("rst_count", retire_count, 64'd0);
        g_resetn = 1'b1;
        step();

        // Sequential PCs: no error
        retire(64'h1000, 64'h1004, 5'd1, 64'h11, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0);
        chk("seq1_err", {63'd0, err_valid}, 64'd0);
        chk("seq1_count", retire_count, 64'd1);
        retire(64'h1004, 64'h1008, 5'd2, 64'h22, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0);
        chk("seq2_err", {63'd0, err_valid}, 64'd0);
        chk("seq2_count", retire_count, 64'd2);

        // PC discontinuity excused by interrupt
        retire(64'h2000, 64'h2004, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1'b1, 1'b0);
        chk("intr_err", {63'd0, err_valid}, 64'd0);
        chk("intr_count", retire_count, 64'd3);

        // PC discontinuity without interrupt
        do_clear();
        chk("clr_count", retire_count, 64'd0);
        retire(64'h1000, 64'h1004, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0);
        retire(64'h2000, 64'h2004, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0);
        chk("pc_err_valid", {63'd0, err_valid}, 64'd1);
        chk("pc_err_code", {61'd0, err_code}, 64'd1);
        chk("pc_sticky", {63'd0, err_sticky}, 64'd1);
        chk("pc_count", retire_count, 64'd2);
        step();
        chk("pc_pulse_end", {63'd0, err_valid}, 64'd0);
        chk("pc_sticky_hold", {63'd0, err_sticky}, 64'd1);
        // Halted: further retirements are ignored, even violating ones
        retire(64'h9000, 64'h9001, 5'd0, 64'h5, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0);
        chk("fail_frozen_count", retire_count, 64'd2);
        chk("fail_no_pulse", {63'd0, err_valid}, 64'd0);

        // Clear with simultaneous retirement: retirement dropped
        rvfi_valid    = 1'b1;
        rvfi_pc_rdata = 64'h3000;
        rvfi_pc_wdata = 64'h3001;
        rvfi_rd_addr  = 5'd0;
        rvfi_rd_wdata = 64'h7;
        do_clear();
        rvfi_valid = 1'b0;
        chk("clrv_sticky", {63'd0, err_sticky}, 64'd0);
        chk("clrv_count", retire_count, 64'd0);
        chk("clrv_err", {63'd0, err_valid}, 64'd0);
        retire(64'h5550, 64'h5554, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0);
        chk("clr_first_err", {63'd0, err_valid}, 64'd0);
        chk("clr_first_count", retire_count, 64'd1);

        // x0 write together with misaligned next PC: code 2 only, single pulse
        retire(64'h5554, 64'h1001, 5'd0, 64'h1, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0);
        chk("x0_err_valid", {63'd0, err_valid}, 64'd1);
        chk("x0_err_code", {61'd0, err_code}, 64'd2);
        step();
        chk("x0_pulse_end", {63'd0, err_valid}, 64'd0);

        // Misaligned next PC alone
        do_clear();
        retire(64'h4000, 64'h4003, 5'd3, 64'h9, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0);
        chk("align_code", {61'd0, err_code}, 64'd5);
        // Same with trap: no alignment check
        do_clear();
        retire(64'h4000, 64'h4003, 5'd3, 64'h9, 5'd0, 0, 5'd0, 0, 1'b0, 1'b1);
        chk("trap_align_err", {63'd0, err_valid}, 64'd0);
        chk("trap_align_count", retire_count, 64'd1);

        // PC and x0 violations together: PC wins
        do_clear();
        retire(64'h0, 64'h4, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0);
        retire(64'h8, 64'hC, 5'd0, 64'h5, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0);
        chk("prio_code", {61'd0, err_code}, 64'd1);

`ifdef RVFI_MONITOR_REGFILE_EN
        // Shadow register file checks
        do_clear();
        retire(64'h100, 64'h104, 5'd5, 64'hDEAD, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0);
        retire(64'h104, 64'h108, 5'd0, 0, 5'd5, 64'hDEAD, 5'd6, 64'h1234, 1'b0, 1'b0);
        chk("rf_match_err", {63'd0, err_valid}, 64'd0);
        retire(64'h108, 64'h10C, 5'd0, 0, 5'd5, 64'hBEEF, 5'd0, 0, 1'b0, 1'b0);
        chk("rf_rs1_code", {61'd0, err_code}, 64'd3);
        do_clear();
        // Same-cycle write of x7 with a stale-free read: x7 unwritten, then rs2 mismatch
        retire(64'h200, 64'h204, 5'd7, 64'h77, 5'd0, 0, 5'd7, 64'h55, 1'b0, 1'b0);
        chk("rf_prewrite_err", {63'd0, err_valid}, 64'd0);
        retire(64'h204, 64'h208, 5'd0, 0, 5'd0, 0, 5'd7, 64'h55, 1'b0, 1'b0);
        chk("rf_rs2_code", {61'd0, err_code}, 64'd4);
`endif

        // Asynchronous reset mid-run clears everything
        #2 g_resetn = 1'b0;
        #1;
        chk("async_rst_sticky", {63'd0, err_sticky}, 64'd0);
        chk("async_rst_count", retire_count, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
